// File: rtl/env_pkg.sv
// Shared types and constants for the envelope follower.
//   sample_t / level_t : 24-bit sample and envelope level
//   calc_t             : 25-bit unsigned working width for envelope arithmetic
//   env_state_t        : follower state encoding (IDLE=0, ATTACK=1, HOLD=2, RELEASE=3)
//   ABS_SAT            : magnitude assigned to the most negative input sample
package env_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned CALC_W   = 25;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SAMPLE_W-1:0] level_t;
  typedef logic [CALC_W-1:0]   calc_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } env_state_t;

  localparam level_t ABS_SAT = 24'h7FFFFF;

endpackage

// File: rtl/env_abs.sv
// Stage 1 of the envelope follower: registered absolute value of a signed
// 24-bit sample. The most negative value has no positive counterpart and is
// saturated to ABS_SAT.
// Ports:
//   clk       : sample-domain clock (rising edge)
//   rst       : synchronous active-high reset, clears the valid flag
//   x         : signed two's-complement sample
//   x_valid   : new-sample strobe
//   abs       : registered magnitude
//   abs_valid : one-cycle strobe, abs holds a fresh magnitude
module env_abs
  import env_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t x,
  input  logic    x_valid,
  output level_t  abs,
  output logic    abs_valid
);

  level_t mag;

  always_comb begin
    mag = x;
    if (x[23]) begin
      mag = (x == 24'h800000) ? ABS_SAT : level_t'(-x);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abs       <= '0;
      abs_valid <= 1'b0;
    end else begin
      abs_valid <= x_valid;
      if (x_valid) begin
        abs <= mag;
      end
    end
  end

endmodule

// File: rtl/env_follow.sv
// Peak envelope follower with attack / optional peak-hold / release and a
// threshold gate. Two-stage pipeline: stage 1 (env_abs) registers |x|,
// stage 2 updates env, state and gate and pulses env_valid.
// Build option: define ENV_PEAK_HOLD_EN to build the HOLD state and its
// sample counter; without it ATTACK falls straight through to RELEASE and
// HOLD_SAMPLES has no effect.
// Ports:
//   clk_48    : 48 kHz sample clock, rising edge
//   rst       : synchronous active-high reset
//   x         : sample, x[23:0] signed, x[31:24] ignored
//   x_valid   : new-sample strobe
//   env       : unsigned envelope level
//   env_valid : one-cycle strobe on each envelope update
//   gate      : registered env >= THRESH
//   state     : current follower state
module env_follow
  import env_pkg::*;
#(
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 8,
  parameter int unsigned HOLD_SAMPLES  = 480,
  parameter level_t      THRESH        = 24'h010000
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic [23:0] env,
  output logic        env_valid,
  output logic        gate,
  output logic [1:0]  state
);

  if (ATTACK_SHIFT < 1 || ATTACK_SHIFT > 8 || RELEASE_SHIFT < 1 ||
      RELEASE_SHIFT > 15 || HOLD_SAMPLES < 1 || HOLD_SAMPLES > 65535) begin : g_bad_param
    $error("env_follow: parameter out of range");
  end

  level_t     abs;
  logic       abs_valid;
  logic       unused_x_hi;

  env_state_t state_q, state_nx;
  level_t     env_q, env_nx;
  calc_t      abs_c, env_c, diff, step, sum;

`ifdef ENV_PEAK_HOLD_EN
  logic [15:0] hold_q, hold_nx;
`endif

  assign unused_x_hi = ^x[31:24];

  env_abs u_abs (
    .clk       (clk_48),
    .rst       (rst),
    .x         (x[23:0]),
    .x_valid   (x_valid),
    .abs       (abs),
    .abs_valid (abs_valid)
  );

  assign abs_c = {1'b0, abs};
  assign env_c = {1'b0, env_q};

  always_comb begin
    state_nx = state_q;
    env_nx   = env_q;
    diff     = '0;
    step     = '0;
    sum      = '0;
`ifdef ENV_PEAK_HOLD_EN
    hold_nx  = hold_q;
`endif
    if (abs_c > env_c) begin
      // Attack: move at least one LSB, never overshoot the input peak.
      diff = abs_c - env_c;
      step = diff >> ATTACK_SHIFT;
      if (step == '0) step = calc_t'(1);
      sum      = env_c + step;
      env_nx   = (sum > abs_c) ? abs : level_t'(sum);
      state_nx = ST_ATTACK;
`ifdef ENV_PEAK_HOLD_EN
      hold_nx  = 16'(HOLD_SAMPLES);
`endif
    end else begin
      unique case (state_q)
        ST_ATTACK: begin
`ifdef ENV_PEAK_HOLD_EN
          if (HOLD_SAMPLES == 1) begin
            state_nx = ST_RELEASE;
          end else begin
            state_nx = ST_HOLD;
            hold_nx  = 16'(HOLD_SAMPLES - 1);
          end
`else
          state_nx = ST_RELEASE;
`endif
        end
`ifdef ENV_PEAK_HOLD_EN
        ST_HOLD: begin
          hold_nx = hold_q - 16'd1;
          if (hold_nx == '0) state_nx = ST_RELEASE;
        end
`endif
        ST_RELEASE: begin
          // Decay by at least one LSB, floored at the current input level.
          diff = env_c - abs_c;
          step = diff >> RELEASE_SHIFT;
          if (step == '0) step = calc_t'(1);
          env_nx = (step >= diff) ? abs : level_t'(env_c - step);
          if (env_nx == '0) state_nx = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      env_q     <= '0;
      gate      <= 1'b0;
      env_valid <= 1'b0;
`ifdef ENV_PEAK_HOLD_EN
      hold_q    <= '0;
`endif
    end else begin
      env_valid <= abs_valid;
      if (abs_valid) begin
        state_q <= state_nx;
        env_q   <= env_nx;
        gate    <= (env_nx >= THRESH);
`ifdef ENV_PEAK_HOLD_EN
        hold_q  <= hold_nx;
`endif
      end
    end
  end

  assign env   = env_q;
  assign state = state_q;

endmodule

// File: tb/tb_env_follow.sv
// Self-checking bench for env_follow. A behavioural model predicts each
// envelope update when a sample is driven; a monitor pops and compares on
// every env_valid pulse. Scenario tasks add literal checks of known values.
module tb_env_follow;

  localparam int unsigned AS = 2;
  localparam int unsigned RS = 8;
  localparam int unsigned HS = 4;
  localparam logic [23:0] TH = 24'h010000;

  logic        clk_48 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] x = '0;
  logic        x_valid = 1'b0;
  logic [23:0] env;
  logic        env_valid;
  logic        gate;
  logic [1:0]  state;

  always #5 clk_48 = ~clk_48;

  env_follow #(
    .ATTACK_SHIFT  (AS),
    .RELEASE_SHIFT (RS),
    .HOLD_SAMPLES  (HS),
    .THRESH        (TH)
  ) dut (
    .clk_48    (clk_48),
    .rst       (rst),
    .x         (x),
    .x_valid   (x_valid),
    .env       (env),
    .env_valid (env_valid),
    .gate      (gate),
    .state     (state)
  );

  typedef struct packed {
    logic [23:0] env;
    logic [1:0]  state;
    logic        gate;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_env, m_state, m_cnt;

  task automatic model_reset();
    m_env = 0; m_state = 0; m_cnt = 0;
    sb.delete();
  endtask

  task automatic model_step(input logic [31:0] xv);
    logic signed [23:0] s;
    int v, a, d, st;
    exp_t e;
    s = xv[23:0];
    v = s;
    a = (v < 0) ? -v : v;
    if (a > 'h7FFFFF) a = 'h7FFFFF;
    if (a > m_env) begin
      d = a - m_env;
      st = d >> AS;
      if (st < 1) st = 1;
      m_env = (m_env + st > a) ? a : m_env + st;
      m_state = 1;
      m_cnt = HS;
    end else if (m_state == 1) begin
`ifdef ENV_PEAK_HOLD_EN
      if (HS == 1) m_state = 3;
      else begin m_state = 2; m_cnt = HS - 1; end
`else
      m_state = 3;
`endif
    end else if (m_state == 2) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_state = 3;
    end else if (m_state == 3) begin
      d = m_env - a;
      st = d >> RS;
      if (st < 1) st = 1;
      m_env = (m_env - st < a) ? a : m_env - st;
      if (m_env == 0) m_state = 0;
    end
    e.env = m_env[23:0];
    e.state = m_state[1:0];
    e.gate = (m_env >= int'(TH));
    sb.push_back(e);
  endtask

  task automatic drive_sample(input logic [31:0] xv);
    model_step(xv);
    x = xv;
    x_valid = 1'b1;
    @(posedge clk_48); #1;
    x_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk_48); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x_valid = 1'b0;
    model_reset();
    repeat (2) begin @(posedge clk_48); #1; end
    rst = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_48);
      if (env_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_env_valid env=%h state=%0d", env, state);
        end else begin
          e = sb.pop_front();
          if (env !== e.env) begin
            errors++;
            $display("FAIL sb_env got=%h exp=%h", env, e.env);
          end
          checks++;
          if (state !== e.state) begin
            errors++;
            $display("FAIL sb_state got=%0d exp=%0d", state, e.state);
          end
          checks++;
          if (gate !== e.gate) begin
            errors++;
            $display("FAIL sb_gate got=%b exp=%b", gate, e.gate);
          end
`ifndef ENV_PEAK_HOLD_EN
          checks++;
          if (state === 2'd2) begin
            errors++;
            $display("FAIL no_hold_state got=%0d exp!=2", state);
          end
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x = 32'h00400000;
    x_valid = 1'b1;
    model_reset();
    repeat (2) begin @(posedge clk_48); #1; end
    checks++;
    if (env !== 24'h0) begin errors++; $display("FAIL reset_env got=%h exp=000000", env); end
    checks++;
    if (env_valid !== 1'b0) begin errors++; $display("FAIL reset_env_valid got=%b exp=0", env_valid); end
    checks++;
    if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate got=%b exp=0", gate); end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst = 1'b0;
    x_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_48); #1;
      checks++;
      if (env_valid !== 1'b0) begin errors++; $display("FAIL reset_priority got=%b exp=0", env_valid); end
    end
  endtask

  task automatic test_attack();
    do_reset();
    drive_sample(32'h00400000);
    wait_drain();
    checks++;
    if (env !== 24'h100000) begin errors++; $display("FAIL attack_env got=%h exp=100000", env); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL attack_state got=%0d exp=1", state); end
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL attack_gate got=%b exp=1", gate); end
  endtask

  task automatic test_latency();
    do_reset();
    x = 32'h00001000;
    x_valid = 1'b1;
    model_step(x);
    @(posedge clk_48); #1;
    x_valid = 1'b0;
    checks++;
    if (env_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", env_valid); end
    @(posedge clk_48); #1;
    checks++;
    if (env_valid !== 1'b1) begin errors++; $display("FAIL latency_n2 got=%b exp=1", env_valid); end
    wait_drain();
  endtask

  task automatic test_saturation();
    do_reset();
    drive_sample(32'hA5800000);
    wait_drain();
    checks++;
    if (env !== 24'h1FFFFF) begin errors++; $display("FAIL sat_env got=%h exp=1fffff", env); end
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL sat_state got=%0d exp=1", state); end
  endtask

  task automatic test_hold_release();
    do_reset();
    drive_sample(32'h00400000);
    wait_drain();
`ifdef ENV_PEAK_HOLD_EN
    for (int k = 1; k <= int'(HS); k++) begin
      drive_sample(32'h0);
      wait_drain();
      checks++;
      if (env !== 24'h100000) begin errors++; $display("FAIL hold_env k=%0d got=%h exp=100000", k, env); end
      checks++;
      if (state !== ((k < int'(HS)) ? 2'd2 : 2'd3)) begin
        errors++;
        $display("FAIL hold_state k=%0d got=%0d exp=%0d", k, state, (k < int'(HS)) ? 2 : 3);
      end
    end
`else
    drive_sample(32'h0);
    wait_drain();
    checks++;
    if (env !== 24'h100000) begin errors++; $display("FAIL nohold_env got=%h exp=100000", env); end
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL nohold_state got=%0d exp=3", state); end
`endif
    drive_sample(32'h0);
    wait_drain();
    checks++;
    if (env !== 24'h0FF000) begin errors++; $display("FAIL release_env got=%h exp=0ff000", env); end
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL release_state got=%0d exp=3", state); end
  endtask

  task automatic test_release_floor();
    logic [23:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) drive_sample(32'h00000003);
    wait_drain();
    checks++;
    if (env !== 24'h000003) begin errors++; $display("FAIL floor_setup got=%h exp=000003", env); end
    for (int i = 0; i < 20 && m_state != 3; i++) drive_sample(32'h0);
    wait_drain();
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL floor_release got=%0d exp=3", state); end
    for (int i = 2; i >= 0; i--) begin
      want = 24'(i);
      drive_sample(32'h0);
      wait_drain();
      checks++;
      if (env !== want) begin errors++; $display("FAIL floor_step got=%h exp=%h", env, want); end
    end
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL floor_idle got=%0d exp=0", state); end
    checks++;
    if (gate !== 1'b0) begin errors++; $display("FAIL floor_gate got=%b exp=0", gate); end
    drive_sample(32'h0);
    wait_drain();
    checks++;
    if (env !== 24'h0 || state !== 2'd0) begin
      errors++;
      $display("FAIL idle_stay env=%h state=%0d exp env=000000 state=0", env, state);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xv;
    logic [23:0] t;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: xv = {$urandom_range(0, 255), 24'h0};
        1: begin
          t = 24'($urandom_range(0, 8));
          if ($urandom_range(0, 1) == 1) t = -t;
          xv = {8'h5A, t};
        end
        2: xv = $urandom;
        default: xv = {8'($urandom_range(0, 255)), 24'h800000};
      endcase
      drive_sample(xv);
    end
    for (int i = 0; i < 40; i++) drive_sample(32'h00000100);
    for (int i = 0; i < 20; i++) drive_sample(32'h0);
    wait_drain();
  endtask

  task automatic test_reset_midpipe();
    do_reset();
    drive_sample(32'h00400000);
    wait_drain();
    x = 32'h00600000;
    x_valid = 1'b1;
    @(posedge clk_48); #1;
    x_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk_48); #1;
    checks++;
    if (env !== 24'h0 || gate !== 1'b0 || state !== 2'd0 || env_valid !== 1'b0) begin
      errors++;
      $display("FAIL midpipe_reset env=%h gate=%b state=%0d ev=%b exp 000000/0/0/0",
               env, gate, state, env_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_48); #1;
      checks++;
      if (env_valid !== 1'b0) begin errors++; $display("FAIL midpipe_pulse got=%b exp=0", env_valid); end
    end
    drive_sample(32'h00400000);
    wait_drain();
    checks++;
    if (env !== 24'h100000) begin errors++; $display("FAIL midpipe_recover got=%h exp=100000", env); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_attack();
    test_latency();
    test_saturation();
    test_hold_release();
    test_release_floor();
    test_back_to_back();
    test_reset_midpipe();
    repeat (3) @(posedge clk_48);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/env_follow.md
ENV_FOLLOW -- requirements
Module: env_follow

Interface
REQ-001 Parameter ATTACK_SHIFT, default 2, attack coefficient as a right-shift (1..8).
REQ-002 Parameter RELEASE_SHIFT, default 8, release coefficient as a right-shift (1..15).
REQ-003 Parameter HOLD_SAMPLES, default 480, peak-hold length in samples (1..65535).
REQ-004 Parameter THRESH, default 24'h010000, gate threshold on env.
REQ-005 clk_48  in  1  the only clock, 48 kHz sample-domain clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 x  in  32  audio sample; x[23:0] is signed two's-complement; x[31:24] is ignored.
REQ-008 x_valid  in  1  one-cycle strobe marking x as a new sample; back-to-back strobes are legal.
REQ-009 env  out  24  unsigned envelope level.
REQ-010 env_valid  out  1  one-cycle strobe marking an env update.
REQ-011 gate  out  1  high when env >= THRESH.
REQ-012 state  out  2  current state encoding, for debug and the bench.

Function
REQ-013 Stage 1: on x_valid, the block SHALL register abs = |x[23:0]|; -8388608 saturates to 24'h7FFFFF.
REQ-014 Stage 2: one cycle after stage 1, the block SHALL update env and state, and pulse env_valid.
REQ-015 Latency: x_valid at cycle n SHALL give env_valid at cycle n+2; env, gate and state SHALL only change on the env_valid cycle.
REQ-016 States: IDLE=0, ATTACK=1, HOLD=2, RELEASE=3; transitions are evaluated only on stage-2 updates.
REQ-017 Any state, abs > env: env += max(1, (abs-env) >> ATTACK_SHIFT), clamped to abs; next = ATTACK; hold_cnt = HOLD_SAMPLES.
REQ-018 ATTACK, abs <= env: env holds; next = HOLD; hold_cnt = HOLD_SAMPLES-1; if HOLD_SAMPLES==1, next = RELEASE instead.
REQ-019 HOLD, abs <= env: env holds; hold_cnt decrements; when hold_cnt reaches 0, next = RELEASE.
REQ-020 RELEASE, abs <= env: env -= max(1, (env-abs) >> RELEASE_SHIFT), floored at abs; once env equals abs, env stays there.
REQ-021 RELEASE: if env == 0 after the update, next = IDLE.
REQ-022 IDLE, abs == 0: env stays 0 and state stays IDLE; env_valid still pulses.
REQ-023 Arithmetic SHALL be 25-bit unsigned internally; env SHALL never wrap above 24'hFFFFFF or below 0.
REQ-024 gate SHALL be a registered compare of the new env against THRESH.

Reset
REQ-025 While rst is high, on each clk_48 edge: env=0, env_valid=0, gate=0, state=IDLE, hold_cnt=0, stage-1 valid=0.
REQ-026 rst asserted mid-pipeline SHALL discard any in-flight sample; no env_valid pulse may follow for it.
REQ-027 rst SHALL take priority over a simultaneous x_valid.

Configuration
REQ-028 Macro ENV_PEAK_HOLD_EN: when defined, the HOLD state and hold_cnt are built as above.
REQ-029 When ENV_PEAK_HOLD_EN is undefined: ATTACK with abs <= env goes directly to RELEASE; state never equals 2; hold_cnt is not built; HOLD_SAMPLES is ignored.

Structure
REQ-030 A shared package env_pkg SHALL hold the state enum, the 24-bit sample/level typedefs and the saturation constant 24'h7FFFFF.
REQ-031 One sub-module, env_abs (stage-1 absolute value with saturation), SHALL be instantiated; all other logic stays in env_follow.

Verification
REQ-032 Reset, then one x=24'h400000 strobe -> env_valid two cycles later; env=24'h100000 (ATTACK_SHIFT=2); state=ATTACK; gate=1.
REQ-033 x=24'h800000 (-8388608) -> abs saturates to 24'h7FFFFF; first env = 24'h1FFFFF.
REQ-034 env=24'h100000, then HOLD_SAMPLES zero-samples with hold enabled -> env unchanged throughout; state HOLD, then RELEASE; next zero gives env = 24'h0FF000.
REQ-035 Same case with ENV_PEAK_HOLD_EN undefined -> RELEASE on the first zero; second zero gives env = 24'h0FF000; state never reads 2.
REQ-036 env=24'h000003 in RELEASE with zero input -> env 2, 1, 0, then state=IDLE and gate=0; no underflow.
REQ-037 rst pulsed one cycle after x_valid -> no env_valid pulse; all outputs at reset values on the next edge.
